pool_win_gen: RTL and testbench

POOL_WIN_GEN -- requirements
Module: pool_win_gen

---
 rtl/pool_pkg.sv | 28 ++
 rtl/pool_line_buf.sv | 34 +++
 rtl/pool_win_gen.sv | 149 ++++++++++++++
 tb/tb_pool_win_gen.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// Shared definitions for the pooling window generator.
// Holds the default geometry of the block and the predicate that decides
// whether the pixel just accepted at (col,row) completes a window.
package pool_pkg;

  localparam int DEF_DW     = 22;
  localparam int DEF_IMG_W  = 28;
  localparam int DEF_IMG_H  = 28;
  localparam int DEF_K      = 2;
  localparam int DEF_STRIDE = 2;

  // True when (col,row) is the bottom-right corner of a window that lies fully
  // inside the current frame and sits on the stride grid.  Windows that would
  // reach into the previous row or frame fail the col/row >= k-1 test, which
  // is what keeps stale line-buffer data from ever reaching the output.
  function automatic logic win_emit(input int col, input int row,
                                    input int k, input int stride);
    logic ok;
    ok = 1'b0;
    if ((col >= k - 1) && (row >= k - 1)) begin
      ok = (((col - k + 1) % stride) == 0) && (((row - k + 1) % stride) == 0);
    end else begin
      ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// One row of pixel history: an IMG_W-deep shift memory that advances only
// when a pixel is accepted, so dout is the pixel exactly one row above the
// one currently on din.  Contents are not reset; the window predicate masks
// anything stale.
// Ports:
//   clk  - rising-edge clock
//   en   - shift enable (pixel accepted)
//   din  - pixel entering the row
//   dout - pixel leaving the row (DEPTH accepted pixels old)
module pool_line_buf #(
  parameter int DW    = 22,
  parameter int DEPTH = 28
) (
  input  logic          clk,
  input  logic          en,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] mem_r [DEPTH];

  // Shift the row history by one pixel on every accepted pixel.
  always_ff @(posedge clk) begin
    if (en) begin
      mem_r[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        mem_r[i] <= mem_r[i-1];
      end
    end
  end

  assign dout = mem_r[DEPTH-1];

endmodule

// File: rtl/pool_win_gen.sv
// Sliding KxK window generator for a raster-order pixel stream.
// Tracks the (col,row) position of each accepted pixel, keeps K-1 rows of
// history in line buffers and a KxK window register, and presents a packed
// window one cycle after the pixel that completes it.
// Ports:
//   clk, rstn  - clock, asynchronous active-low reset
//   in_valid   - pixel accepted this cycle (no backpressure)
//   in_sof     - with in_valid: this pixel is (0,0) of a new frame
//   in_data    - pixel value
//   win_valid  - a window is on win_data this cycle
//   win_data   - element (r,c) at [(r*K+c)*DW +: DW], r=0 oldest row, c=0 leftmost
//   win_last   - this window was completed by the last pixel of the frame
module pool_win_gen
  import pool_pkg::*;
#(
  parameter int DW     = DEF_DW,
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int K      = DEF_K,
  parameter int STRIDE = DEF_STRIDE
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  input  logic                 in_sof,
  input  logic signed [DW-1:0] in_data,
  output logic                 win_valid,
  output logic [K*K*DW-1:0]    win_data,
  output logic                 win_last
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [CW-1:0] col_r;
  logic [RW-1:0] row_r;
  logic [CW-1:0] eff_col_s;
  logic [RW-1:0] eff_row_s;
  logic          col_end_s;
  logic          row_end_s;
  logic          emit_s;
  logic          last_s;

  logic [DW-1:0] lb_in_s  [K-1];
  logic [DW-1:0] lb_out_s [K-1];
  logic [DW-1:0] col_s    [K];
  logic [DW-1:0] win_r    [K][K];
  logic [DW-1:0] win_nxt_s[K][K];
  logic [K*K*DW-1:0] pack_s;

  // Line buffers are chained: buffer g delays by (g+1) rows.
  for (genvar g = 0; g < K - 1; g++) begin : g_lb
    if (g == 0) begin : g_first
      assign lb_in_s[g] = in_data;
    end else begin : g_chain
      assign lb_in_s[g] = lb_out_s[g-1];
    end
    pool_line_buf #(.DW(DW), .DEPTH(IMG_W)) u_line_buf (
      .clk  (clk),
      .en   (in_valid),
      .din  (lb_in_s[g]),
      .dout (lb_out_s[g])
    );
  end

  // Position of the incoming pixel (in_sof forces the origin) and the emit decision.
  always_comb begin
    eff_col_s = col_r;
    eff_row_s = row_r;
    if (in_sof) begin
      eff_col_s = '0;
      eff_row_s = '0;
    end else begin
      eff_col_s = col_r;
      eff_row_s = row_r;
    end
    col_end_s = (eff_col_s == CW'(IMG_W - 1));
    row_end_s = (eff_row_s == RW'(IMG_H - 1));
    emit_s    = in_valid & win_emit(int'(eff_col_s), int'(eff_row_s), K, STRIDE);
    last_s    = emit_s & col_end_s & row_end_s;
  end

  // Next window: shift left one column, newest column = line-buffer taps over in_data.
  always_comb begin
    for (int r = 0; r < K - 1; r++) begin
      col_s[r] = lb_out_s[K-2-r];
    end
    col_s[K-1] = in_data;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) begin
        win_nxt_s[r][c] = win_r[r][c+1];
      end
      win_nxt_s[r][K-1] = col_s[r];
    end
    pack_s = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        pack_s[(r*K+c)*DW +: DW] = win_nxt_s[r][c];
      end
    end
  end

  // Raster position counters; advance only on accepted pixels.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col_r <= '0;
      row_r <= '0;
    end else if (in_valid) begin
      if (col_end_s) begin
        col_r <= '0;
        row_r <= row_end_s ? '0 : eff_row_s + RW'(1);
      end else begin
        col_r <= eff_col_s + CW'(1);
        row_r <= eff_row_s;
      end
    end
  end

  // Window register; cleared on reset so an aborted frame leaves nothing behind.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          win_r[r][c] <= '0;
        end
      end
    end else if (in_valid) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          win_r[r][c] <= win_nxt_s[r][c];
        end
      end
    end
  end

  // Registered outputs; data is forced to zero whenever no window is presented.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      win_valid <= 1'b0;
      win_last  <= 1'b0;
      win_data  <= '0;
    end else begin
      win_valid <= emit_s;
      win_last  <= last_s;
      win_data  <= emit_s ? pack_s : '0;
    end
  end

endmodule

// File: tb/tb_pool_win_gen.sv
// Self-checking bench for pool_win_gen: two instances (K=2/S=2/4x4 and
// K=3/S=1/5x5) checked cycle by cycle against an image-array reference model,
// plus fixed window values for the ramp scenarios.
module tb_pool_win_gen;

  localparam int DW = 22;
  localparam int XW = 9 * DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rstn;
  logic           iv   [2];
  logic           isof [2];
  logic [DW-1:0]  idat [2];
  logic           wv   [2];
  logic           wl   [2];
  logic [4*DW-1:0] wd_a;
  logic [9*DW-1:0] wd_b;
  logic [XW-1:0]  obs  [2];

  pool_win_gen #(.DW(DW), .IMG_W(4), .IMG_H(4), .K(2), .STRIDE(2)) dut_a (
    .clk(clk), .rstn(rstn), .in_valid(iv[0]), .in_sof(isof[0]), .in_data(idat[0]),
    .win_valid(wv[0]), .win_data(wd_a), .win_last(wl[0]));

  pool_win_gen #(.DW(DW), .IMG_W(5), .IMG_H(5), .K(3), .STRIDE(1)) dut_b (
    .clk(clk), .rstn(rstn), .in_valid(iv[1]), .in_sof(isof[1]), .in_data(idat[1]),
    .win_valid(wv[1]), .win_data(wd_b), .win_last(wl[1]));

  assign obs[0] = {{(XW-4*DW){1'b0}}, wd_a};
  assign obs[1] = wd_b;

  int tests  = 0;
  int failed = 0;

  // Reference model: geometry per instance, current position, and the frame image.
  int pk[2] = '{2, 3};
  int ps[2] = '{2, 1};
  int pw[2] = '{4, 5};
  int ph[2] = '{4, 5};
  int m_col[2];
  int m_row[2];
  logic [DW-1:0] img [2][5][5];
  logic          e_valid [2];
  logic          e_last  [2];
  logic [XW-1:0] e_data  [2];

  logic [XW-1:0] win_q  [$];
  logic          last_q [$];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_col[d] = 0; m_row[d] = 0;
      e_valid[d] = 1'b0; e_last[d] = 1'b0; e_data[d] = '0;
    end
  endtask

  // Expected output for the cycle after a pixel, from the image and the window rules.
  task automatic model_step(input int d, input bit v, input bit sof, input logic [DW-1:0] px);
    int ec, er, k;
    bit emit;
    k = pk[d];
    e_valid[d] = 1'b0; e_last[d] = 1'b0; e_data[d] = '0;
    if (v) begin
      ec = sof ? 0 : m_col[d];
      er = sof ? 0 : m_row[d];
      img[d][er][ec] = px;
      emit = (ec >= k - 1) && (er >= k - 1) &&
             ((ec - k + 1) % ps[d] == 0) && ((er - k + 1) % ps[d] == 0);
      if (emit) begin
        e_valid[d] = 1'b1;
        e_last[d]  = (ec == pw[d] - 1) && (er == ph[d] - 1);
        for (int r = 0; r < k; r++)
          for (int c = 0; c < k; c++)
            e_data[d][(r*k+c)*DW +: DW] = img[d][er-k+1+r][ec-k+1+c];
      end
      if (ec == pw[d] - 1) begin
        m_col[d] = 0;
        m_row[d] = (er == ph[d] - 1) ? 0 : er + 1;
      end else begin
        m_col[d] = ec + 1;
        m_row[d] = er;
      end
    end
  endtask

  // Window of a ramp image (pixel value = row*w + col + offset) with top-left value base.
  function automatic logic [XW-1:0] ramp_win(input int k, input int w, input int base);
    logic [XW-1:0] v;
    v = '0;
    for (int r = 0; r < k; r++)
      for (int c = 0; c < k; c++)
        v[(r*k+c)*DW +: DW] = DW'(base + r * w + c);
    return v;
  endfunction

  // One clock: drive instance d, idle the other (with junk sof/data), advance model.
  task automatic step(input int d, input bit v, input bit sof, input logic [DW-1:0] px);
    int o;
    o = 1 - d;
    iv[d] = v; isof[d] = sof; idat[d] = px;
    iv[o] = 1'b0; isof[o] = 1'($urandom_range(0, 1)); idat[o] = DW'($urandom);
    model_step(d, v, sof, px);
    model_step(o, 1'b0, 1'b0, '0);
    @(posedge clk);
    @(negedge clk);
    if (wv[d] === 1'b1) begin
      win_q.push_back(obs[d]);
      last_q.push_back(wl[d]);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b0; isof[d] = 1'b0; idat[d] = '0;
    end
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    win_q.delete();
    last_q.delete();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b0; isof[d] = 1'b0; idat[d] = '0;
    end
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (wv[d] !== 1'b0 || wl[d] !== 1'b0 || obs[d] !== '0) begin
        failed++;
        $display("FAIL reset_state dut%0d: got v=%b l=%b d=%h, expected all zero", d, wv[d], wl[d], obs[d]);
      end
    end
    rstn = 1'b1;
    for (int p = 0; p < 6; p++) step(0, 1'b1, p == 0, DW'(p + 7));
    tests++;
    if (wv[0] !== 1'b1 || obs[0] !== ramp_win(2, 4, 7)) begin
      failed++;
      $display("FAIL reset_pre_window: got v=%b d=%h, expected v=1 d=%h", wv[0], obs[0], ramp_win(2, 4, 7));
    end
    rstn = 1'b0;
    model_reset();
    #1;
    tests++;
    if (wv[0] !== 1'b0 || wl[0] !== 1'b0 || obs[0] !== '0) begin
      failed++;
      $display("FAIL reset_async_clear: got v=%b l=%b d=%h, expected all zero", wv[0], wl[0], obs[0]);
    end
    do_reset();
  endtask

  task automatic test_ramp_k2();
    do_reset();
    for (int p = 0; p < 18; p++) begin
      step(0, p < 16, p == 0, DW'(p));
      tests++;
      if (wv[0] !== e_valid[0] || wl[0] !== e_last[0] || obs[0] !== e_data[0]) begin
        failed++;
        $display("FAIL ramp_k2 cyc%0d: got v=%b l=%b d=%h, expected v=%b l=%b d=%h",
                 p, wv[0], wl[0], obs[0], e_valid[0], e_last[0], e_data[0]);
      end
    end
    tests++;
    if (win_q.size() != 4) begin
      failed++;
      $display("FAIL ramp_k2_count: got %0d windows, expected 4", win_q.size());
    end else begin
      tests++;
      if (win_q[0] !== ramp_win(2, 4, 0) || win_q[3] !== ramp_win(2, 4, 10) ||
          last_q[3] !== 1'b1 || last_q[0] !== 1'b0) begin
        failed++;
        $display("FAIL ramp_k2_ends: got first=%h last=%h lastflag=%b, expected first=%h last=%h lastflag=1",
                 win_q[0], win_q[3], last_q[3], ramp_win(2, 4, 0), ramp_win(2, 4, 10));
      end
    end
  endtask

  task automatic test_ramp_k3();
    do_reset();
    for (int p = 0; p < 27; p++) begin
      step(1, p < 25, p == 0, DW'(p));
      tests++;
      if (wv[1] !== e_valid[1] || wl[1] !== e_last[1] || obs[1] !== e_data[1]) begin
        failed++;
        $display("FAIL ramp_k3 cyc%0d: got v=%b l=%b d=%h, expected v=%b l=%b d=%h",
                 p, wv[1], wl[1], obs[1], e_valid[1], e_last[1], e_data[1]);
      end
    end
    tests++;
    if (win_q.size() != 9) begin
      failed++;
      $display("FAIL ramp_k3_count: got %0d windows, expected 9", win_q.size());
    end else begin
      tests++;
      if (win_q[0] !== ramp_win(3, 5, 0) || win_q[8] !== ramp_win(3, 5, 12) || last_q[8] !== 1'b1) begin
        failed++;
        $display("FAIL ramp_k3_ends: got first=%h last=%h lastflag=%b, expected first=%h last=%h lastflag=1",
                 win_q[0], win_q[8], last_q[8], ramp_win(3, 5, 0), ramp_win(3, 5, 12));
      end
    end
  endtask

  task automatic test_gaps();
    int cyc;
    cyc = 0;
    do_reset();
    for (int p = 0; p < 17; p++) begin
      int gap;
      gap = (p == 0) ? 0 : $urandom_range(1, 3);
      for (int g = 0; g <= gap; g++) begin
        if (g < gap || p == 16) step(0, 1'b0, 1'($urandom_range(0, 1)), DW'($urandom));
        else step(0, 1'b1, p == 0, DW'(p));
        cyc++;
        tests++;
        if (wv[0] !== e_valid[0] || wl[0] !== e_last[0] || obs[0] !== e_data[0]) begin
          failed++;
          $display("FAIL gaps cyc%0d: got v=%b l=%b d=%h, expected v=%b l=%b d=%h",
                   cyc, wv[0], wl[0], obs[0], e_valid[0], e_last[0], e_data[0]);
        end
      end
    end
    tests++;
    if (win_q.size() != 4) begin
      failed++;
      $display("FAIL gaps_count: got %0d windows, expected 4", win_q.size());
    end else begin
      tests++;
      if (win_q[0] !== ramp_win(2, 4, 0) || win_q[1] !== ramp_win(2, 4, 2) ||
          win_q[2] !== ramp_win(2, 4, 8) || win_q[3] !== ramp_win(2, 4, 10) || last_q[3] !== 1'b1) begin
        failed++;
        $display("FAIL gaps_sequence: got w0=%h w3=%h, expected w0=%h w3=%h",
                 win_q[0], win_q[3], ramp_win(2, 4, 0), ramp_win(2, 4, 10));
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int p = 0; p < 33; p++) begin
      step(0, p < 32, (p == 0) || (p == 16), DW'((p < 16) ? p : 100 + p - 16));
      tests++;
      if (wv[0] !== e_valid[0] || wl[0] !== e_last[0] || obs[0] !== e_data[0]) begin
        failed++;
        $display("FAIL back_to_back cyc%0d: got v=%b l=%b d=%h, expected v=%b l=%b d=%h",
                 p, wv[0], wl[0], obs[0], e_valid[0], e_last[0], e_data[0]);
      end
    end
    tests++;
    if (win_q.size() != 8) begin
      failed++;
      $display("FAIL b2b_count: got %0d windows, expected 8", win_q.size());
    end else begin
      tests++;
      if (win_q[4] !== ramp_win(2, 4, 100) || win_q[7] !== ramp_win(2, 4, 110)) begin
        failed++;
        $display("FAIL b2b_second_frame: got first=%h last=%h, expected first=%h last=%h",
                 win_q[4], win_q[7], ramp_win(2, 4, 100), ramp_win(2, 4, 110));
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int p = 0; p < 7; p++) step(0, 1'b1, p == 0, DW'(p + 50));
    rstn = 1'b0;
    model_reset();
    #1;
    tests++;
    if (wv[0] !== 1'b0 || obs[0] !== '0) begin
      failed++;
      $display("FAIL reset_mid_clear: got v=%b d=%h, expected v=0 d=0", wv[0], obs[0]);
    end
    @(negedge clk);
    rstn = 1'b1;
    win_q.delete();
    last_q.delete();
    // Fresh frame without in_sof: the reset alone must restart at (0,0).
    for (int p = 0; p < 17; p++) begin
      step(0, p < 16, 1'b0, DW'(p));
      tests++;
      if (wv[0] !== e_valid[0] || wl[0] !== e_last[0] || obs[0] !== e_data[0]) begin
        failed++;
        $display("FAIL reset_mid cyc%0d: got v=%b l=%b d=%h, expected v=%b l=%b d=%h",
                 p, wv[0], wl[0], obs[0], e_valid[0], e_last[0], e_data[0]);
      end
    end
    tests++;
    if (win_q.size() != 4 || win_q[0] !== ramp_win(2, 4, 0)) begin
      failed++;
      $display("FAIL reset_mid_fresh: got %0d windows first=%h, expected 4 first=%h",
               win_q.size(), (win_q.size() > 0) ? win_q[0] : '0, ramp_win(2, 4, 0));
    end
  endtask

  task automatic test_sof_restart();
    do_reset();
    for (int p = 0; p < 26; p++) begin
      step(0, p < 25, (p == 0) || (p == 9), DW'(p));
      tests++;
      if (wv[0] !== e_valid[0] || wl[0] !== e_last[0] || obs[0] !== e_data[0]) begin
        failed++;
        $display("FAIL sof_restart cyc%0d: got v=%b l=%b d=%h, expected v=%b l=%b d=%h",
                 p, wv[0], wl[0], obs[0], e_valid[0], e_last[0], e_data[0]);
      end
    end
    tests++;
    if (win_q.size() != 6) begin
      failed++;
      $display("FAIL sof_restart_count: got %0d windows, expected 6", win_q.size());
    end else begin
      tests++;
      if (win_q[2] !== ramp_win(2, 4, 9) || win_q[5] !== ramp_win(2, 4, 19) || last_q[5] !== 1'b1) begin
        failed++;
        $display("FAIL sof_restart_origin: got first=%h last=%h, expected first=%h last=%h",
                 win_q[2], win_q[5], ramp_win(2, 4, 9), ramp_win(2, 4, 19));
      end
    end
  endtask

  task automatic test_random_k3();
    int cyc;
    cyc = 0;
    do_reset();
    for (int f = 0; f < 2; f++) begin
      for (int p = 0; p < 25; p++) begin
        int gap;
        gap = $urandom_range(0, 2);
        for (int g = 0; g <= gap; g++) begin
          if (g < gap) step(1, 1'b0, 1'($urandom_range(0, 1)), DW'($urandom));
          else step(1, 1'b1, p == 0, DW'($urandom));
          cyc++;
          tests++;
          if (wv[1] !== e_valid[1] || wl[1] !== e_last[1] || obs[1] !== e_data[1]) begin
            failed++;
            $display("FAIL random_k3 cyc%0d: got v=%b l=%b d=%h, expected v=%b l=%b d=%h",
                     cyc, wv[1], wl[1], obs[1], e_valid[1], e_last[1], e_data[1]);
          end
        end
      end
    end
    step(1, 1'b0, 1'b0, '0);
    tests++;
    if (win_q.size() != 18) begin
      failed++;
      $display("FAIL random_k3_count: got %0d windows, expected 18", win_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_ramp_k2();
    test_ramp_k3();
    test_gaps();
    test_back_to_back();
    test_reset_mid();
    test_sof_restart();
    test_random_k3();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
